// File: rtl/ir_note_sequencer.sv
// Plays IR button presses through a FIFO as evenly timed notes.
// Each note is held for NOTE_CYCLES cycles, followed by GAP_CYCLES cycles of silence.
// The FLUSH_CODE button clears the queue and silences the output at once.
module ir_note_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NOTE_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 1250000,
  parameter logic [3:0]  FLUSH_CODE  = 4'hF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 btn_in,
  output logic [3:0]                 note_out,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW      = $clog2(DEPTH + 1);
  localparam int unsigned MaxCycles = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0] NoteLoad = TimerW'(NOTE_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLoad  = TimerW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        note_q, note_d;
  logic [3:0]        btn_q;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              overflow_q;
  logic [3:0]        mem_q [DEPTH];

  logic press, flush, push_req, push, pop, full_w;

  // A press is an edge to a nonzero code, so a held button only counts once.
  assign press    = (btn_in != btn_q) && (btn_in != 4'd0);
  assign flush    = press && (btn_in == FLUSH_CODE);
  assign push_req = press && !flush;
  assign full_w   = (count_q == CntW'(DEPTH));
  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign push     = push_req && (!full_w || pop);

  // FSM next state, note output and timer reload
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    note_d  = note_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        note_d = 4'd0;
        if (count_q != '0) begin
          pop     = 1'b1;
          note_d  = mem_q[rd_ptr_q];
          timer_d = NoteLoad;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (timer_q == '0) begin
          note_d  = 4'd0;
          timer_d = GapLoad;
          state_d = StGap;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StGap: begin
        if (timer_q == '0) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            note_d  = mem_q[rd_ptr_q];
            timer_d = NoteLoad;
            state_d = StPlay;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: begin
        note_d  = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  // State, timer, pointers and count; a flush overrides everything else on its edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      note_q     <= 4'd0;
      btn_q      <= 4'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      btn_q      <= btn_in;
      overflow_q <= push_req && full_w && !pop;
      if (flush) begin
        state_q  <= StIdle;
        timer_q  <= '0;
        note_q   <= 4'd0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        note_q  <= note_d;
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop) begin
          count_q <= count_q + CntW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CntW'(1);
        end
      end
    end
  end

  // FIFO storage; entries beyond the pointers are never read, so they need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= btn_in;
  end

  assign note_out = note_q;
  assign busy     = (state_q != StIdle);
  assign count    = count_q;
  assign full     = full_w;
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ir_note_sequencer.sv
// Directed self-checking bench for ir_note_sequencer (DEPTH=4, NOTE_CYCLES=4, GAP_CYCLES=2).
module tb_ir_note_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NOTE  = 4;
  localparam int unsigned GAP   = 2;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] note_out;
  logic       busy;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ir_note_sequencer #(
    .DEPTH      (DEPTH),
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES (GAP),
    .FLUSH_CODE (4'hF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_in  (btn_in),
    .note_out(note_out),
    .busy    (busy),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next edge pops note n: expect n for NOTE cycles, then silence for GAP cycles.
  task automatic expect_note(input string tag, input logic [3:0] n);
    for (int i = 0; i < NOTE; i++) begin
      tick();
      chk({tag, " note"}, note_out, n);
    end
    for (int i = 0; i < GAP; i++) begin
      tick();
      chk({tag, " gap"}, note_out, 4'd0);
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hits;
    reset  = 1'b1;
    btn_in = 4'd0;
    tick();
    tick();
    chk("rst note", note_out, 4'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst count", count, 3'd0);
    chk("rst full", full, 1'b0);
    chk("rst empty", empty, 1'b1);
    chk("rst ovf", overflow, 1'b0);
    reset = 1'b0;
    tick();

    // Single press: push at E0, tone from E1
    btn_in = 4'd3;
    tick();
    chk("single count", count, 3'd1);
    chk("single pre", note_out, 4'd0);
    chk("single busy0", busy, 1'b0);
    expect_note("single", 4'd3);
    chk("single busy gap", busy, 1'b1);
    tick();
    chk("single idle", busy, 1'b0);
    btn_in = 4'd0;
    tick();

    // Burst 1,0,2,0,5
    btn_in = 4'd1; tick();
    btn_in = 4'd0; tick();
    chk("burst n1", note_out, 4'd1);
    btn_in = 4'd2; tick();
    btn_in = 4'd0; tick();
    btn_in = 4'd5; tick();
    chk("burst peak", count, 3'd2);
    chk("burst n1 end", note_out, 4'd1);
    btn_in = 4'd0;
    tick(); chk("burst g1a", note_out, 4'd0);
    tick(); chk("burst g1b", note_out, 4'd0);
    expect_note("burst2", 4'd2);
    expect_note("burst5", 4'd5);
    tick();
    chk("burst idle", busy, 1'b0);
    chk("burst empty", empty, 1'b1);

    // Held button yields one note; release and re-press yields another
    btn_in = 4'd6;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (note_out == 4'd6) hits++;
    end
    chk("held hits", hits, NOTE);
    chk("held idle", busy, 1'b0);
    chk("held count", count, 3'd0);
    btn_in = 4'd0; tick();
    btn_in = 4'd6; tick();
    chk("repeat count", count, 3'd1);
    expect_note("repeat", 4'd6);
    btn_in = 4'd0; tick();
    chk("repeat idle", busy, 1'b0);

    // Overflow: six distinct presses, one per cycle
    btn_in = 4'd1; tick();
    btn_in = 4'd2; tick();
    chk("ovf pop+push cnt", count, 3'd1);
    chk("ovf playing", note_out, 4'd1);
    btn_in = 4'd3; tick();
    btn_in = 4'd4; tick();
    btn_in = 4'd5; tick();
    chk("ovf full", full, 1'b1);
    chk("ovf no pulse yet", overflow, 1'b0);
    btn_in = 4'd6; tick();
    chk("ovf pulse", overflow, 1'b1);
    chk("ovf count", count, 3'd4);
    btn_in = 4'd0; tick();
    chk("ovf pulse end", overflow, 1'b0);
    chk("ovf still full", full, 1'b1);
    expect_note("ovf2", 4'd2);
    expect_note("ovf3", 4'd3);
    expect_note("ovf4", 4'd4);
    expect_note("ovf5", 4'd5);
    tick();
    chk("ovf idle", busy, 1'b0);
    chk("ovf empty", empty, 1'b1);

    // Flush while the first of four notes plays
    btn_in = 4'd1; tick();
    btn_in = 4'd2; tick();
    btn_in = 4'd3; tick();
    btn_in = 4'd4; tick();
    chk("flush pre cnt", count, 3'd3);
    chk("flush pre note", note_out, 4'd1);
    btn_in = 4'hF; tick();
    chk("flush note", note_out, 4'd0);
    chk("flush count", count, 3'd0);
    chk("flush empty", empty, 1'b1);
    chk("flush busy", busy, 1'b0);
    btn_in = 4'd0; tick();
    chk("flush stays idle", busy, 1'b0);
    btn_in = 4'd2; tick();
    chk("flush new cnt", count, 3'd1);
    expect_note("post flush", 4'd2);
    btn_in = 4'd0; tick();
    chk("post flush idle", busy, 1'b0);

    // Asynchronous reset during GAP with two entries queued
    btn_in = 4'd1; tick();
    btn_in = 4'd2; tick();
    btn_in = 4'd3; tick();
    btn_in = 4'd0;
    tick(); tick(); tick();
    chk("gap state note", note_out, 4'd0);
    chk("gap state busy", busy, 1'b1);
    chk("gap state count", count, 3'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("async note", note_out, 4'd0);
    chk("async busy", busy, 1'b0);
    chk("async count", count, 3'd0);
    chk("async empty", empty, 1'b1);
    chk("async full", full, 1'b0);
    chk("async ovf", overflow, 1'b0);
    #1;
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (note_out != 4'd0 || busy) hits++;
    end
    chk("post rst silent", hits, 0);
    btn_in = 4'd7; tick();
    chk("post rst cnt", count, 3'd1);
    expect_note("post rst", 4'd7);
    btn_in = 4'd0; tick();
    chk("post rst idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
